// File: rtl/ifft_serial_if.sv
// Valid/ready bin input and time-sample output bundle for the serial 8-point IFFT.
interface ifft_serial_if #(
  parameter int DW = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_r;
  logic signed [DW-1:0] in_i;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_r;
  logic signed [DW-1:0] out_i;
  logic                 out_last;
  logic                 busy;

  modport master (
    output in_valid, in_r, in_i, out_ready,
    input  in_ready, out_valid, out_r, out_i, out_last, busy
  );

  modport slave (
    input  in_valid, in_r, in_i, out_ready,
    output in_ready, out_valid, out_r, out_i, out_last, busy
  );
endinterface

// File: rtl/ifft_serial.sv
// Streaming radix-2 DIT inverse FFT: load bins bit-reversed, one in-place
// butterfly per cycle with conjugate twiddles and per-stage halving, unload in natural order.
module ifft_serial #(
  parameter int N    = 8,
  parameter int DW   = 16,
  parameter int FRAC = 14
) (
  input  logic         clk,
  input  logic         rst,
  ifft_serial_if.slave io
);
  localparam int STAGES = $clog2(N);
  localparam int AW     = STAGES;
  localparam int BW     = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int SW     = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int PW     = DW + FRAC + 1;
  localparam int TW     = FRAC + 2;

  localparam logic signed [TW-1:0] ONE = TW'(1 << FRAC);
  localparam logic signed [TW-1:0] C45 = TW'(((longint'(46341) << FRAC) + 32768) >> 16);
  localparam logic signed [PW-1:0] RND = PW'(1 << (FRAC - 1));

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  state_t state, state_nxt;

  logic [AW-1:0] k_cnt;
  logic [AW-1:0] n_cnt;
  logic [SW-1:0] stg;
  logic [BW-1:0] bfly;

  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 out_last_q;
  logic signed [DW-1:0] out_r_q;
  logic signed [DW-1:0] out_i_q;

  logic signed [DW-1:0] mem_r [N];
  logic signed [DW-1:0] mem_i [N];

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int b = 0; b < AW; b++) r[b] = v[AW-1-b];
    return r;
  endfunction

  // Table holds the N = 8 twiddles exp(+j*2*pi*m/8), m = 0..3.
  function automatic logic signed [TW-1:0] tw_cos(input logic [BW-1:0] m);
    case (m)
      BW'(0):  return ONE;
      BW'(1):  return C45;
      BW'(2):  return '0;
      default: return -C45;
    endcase
  endfunction

  function automatic logic signed [TW-1:0] tw_sin(input logic [BW-1:0] m);
    case (m)
      BW'(0):  return '0;
      BW'(1):  return C45;
      BW'(2):  return ONE;
      default: return C45;
    endcase
  endfunction

  function automatic logic signed [DW:0] round_tw(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] q;
    q = (p + RND) >>> FRAC;
    return q[DW:0];
  endfunction

  function automatic logic signed [DW-1:0] half_trunc(input logic signed [DW+1:0] v);
    logic signed [DW+1:0] h;
    h = v >>> 1;
    return h[DW-1:0];
  endfunction

  logic in_fire, out_fire, last_bf, load_out;

  assign in_fire  = io.in_valid && in_ready_q;
  assign out_fire = out_valid_q && io.out_ready;
  assign last_bf  = (stg == SW'(STAGES - 1)) && (bfly == BW'(N / 2 - 1));
  assign load_out = (state == UNLOAD) && (!out_valid_q || (io.out_ready && !out_last_q));

  // p0: address generation, twiddle lookup and butterfly, written back on the same edge
  logic                 bf_vld_p0;
  logic [AW-1:0]        hmask_p0, pos_p0, a_idx_p0, b_idx_p0;
  logic [BW-1:0]        tw_m_p0;
  logic signed [TW-1:0] w_r_p0, w_i_p0;
  logic signed [PW-1:0] tr_full_p0, ti_full_p0;
  logic signed [DW:0]   t_r_p0, t_i_p0;
  logic signed [DW-1:0] ya_r_p0, ya_i_p0, yb_r_p0, yb_i_p0;

  assign bf_vld_p0 = (state == COMPUTE);

  always_comb begin
    hmask_p0   = AW'((1 << stg) - 1);
    pos_p0     = AW'(bfly) & hmask_p0;
    a_idx_p0   = ((AW'(bfly) & ~hmask_p0) << 1) | pos_p0;
    b_idx_p0   = a_idx_p0 | AW'(1 << stg);
    tw_m_p0    = BW'(pos_p0 << (STAGES - 1 - int'(stg)));
    w_r_p0     = tw_cos(tw_m_p0);
    w_i_p0     = tw_sin(tw_m_p0);
    tr_full_p0 = PW'(mem_r[b_idx_p0]) * PW'(w_r_p0) - PW'(mem_i[b_idx_p0]) * PW'(w_i_p0);
    ti_full_p0 = PW'(mem_r[b_idx_p0]) * PW'(w_i_p0) + PW'(mem_i[b_idx_p0]) * PW'(w_r_p0);
    t_r_p0     = round_tw(tr_full_p0);
    t_i_p0     = round_tw(ti_full_p0);
    ya_r_p0    = half_trunc((DW+2)'(mem_r[a_idx_p0]) + (DW+2)'(t_r_p0));
    ya_i_p0    = half_trunc((DW+2)'(mem_i[a_idx_p0]) + (DW+2)'(t_i_p0));
    yb_r_p0    = half_trunc((DW+2)'(mem_r[a_idx_p0]) - (DW+2)'(t_r_p0));
    yb_i_p0    = half_trunc((DW+2)'(mem_i[a_idx_p0]) - (DW+2)'(t_i_p0));
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (in_fire && (k_cnt == AW'(N - 1))) state_nxt = COMPUTE;
      COMPUTE: if (last_bf) state_nxt = UNLOAD;
      UNLOAD:  if (out_fire && out_last_q) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_cnt       <= '0;
      n_cnt       <= '0;
      stg         <= '0;
      bfly        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
    end else begin
      in_ready_q <= (state_nxt == LOAD);
      if (in_fire) k_cnt <= k_cnt + 1'b1;
      if (bf_vld_p0) begin
        bfly <= bfly + 1'b1;
        if (bfly == BW'(N / 2 - 1)) stg <= last_bf ? '0 : stg + 1'b1;
      end
      // p1: output register holds its sample until the downstream takes it
      if (load_out) begin
        out_valid_q <= 1'b1;
        out_r_q     <= mem_r[n_cnt];
        out_i_q     <= mem_i[n_cnt];
        out_last_q  <= (n_cnt == AW'(N - 1));
        n_cnt       <= n_cnt + 1'b1;
      end else if (out_fire && out_last_q) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_r[bitrev(k_cnt)] <= io.in_r;
      mem_i[bitrev(k_cnt)] <= io.in_i;
    end else if (bf_vld_p0) begin
      mem_r[a_idx_p0] <= ya_r_p0;
      mem_i[a_idx_p0] <= ya_i_p0;
      mem_r[b_idx_p0] <= yb_r_p0;
      mem_i[b_idx_p0] <= yb_i_p0;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_last  = out_last_q;
  assign io.out_r     = out_r_q;
  assign io.out_i     = out_i_q;
  assign io.busy      = (state != LOAD);
endmodule
